// File: rtl/countdown_timer.sv
// Countdown timer: synchronized start/pause and load buttons, 1-tick-per-TICK_DIV prescaler,
// and a WIDTH-bit down-counter that feeds the two-digit hex display stage.
module countdown_timer #(
    parameter int WIDTH       = 6,
    parameter int TICK_DIV    = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             load_btn,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             done_pulse
);

    // state | meaning
    // IDLE  | holding count, waiting for start or load
    // RUN   | prescaler counting, count decrements on each tick
    // PAUSE | count and prescaler frozen
    // DONE  | count reached zero, start reloads from the reload register
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [WIDTH-1:0]       reload_q, reload_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [SYNC_STAGES-1:0] start_sync_q, load_sync_q;
    logic                   start_prev_q, load_prev_q;
    logic                   running_q, done_q, done_pulse_q;
    logic                   start_ev, load_ev, tick, enter_done;

    assign start_ev = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
    assign load_ev  = load_sync_q[SYNC_STAGES-1] & ~load_prev_q;
    assign tick     = (state_q == RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        enter_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_ev) begin
                    count_d  = load_val;
                    reload_d = load_val;
                end else if (start_ev) begin
                    if (count_q != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load_ev) begin
                    count_d  = load_val;
                    reload_d = load_val;
                    state_d  = IDLE;
                end else if (start_ev) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    if (count_q > WIDTH'(1)) begin
                        count_d = count_q - 1'b1;
                    end else begin
                        count_d    = '0;
                        state_d    = DONE;
                        enter_done = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (load_ev) begin
                    count_d  = load_val;
                    reload_d = load_val;
                    state_d  = IDLE;
                end else if (start_ev) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                count_d = '0;
                if (load_ev) begin
                    count_d  = load_val;
                    reload_d = load_val;
                    state_d  = IDLE;
                end else if (start_ev) begin
                    count_d = reload_q;
                    if (reload_q != '0) begin
                        state_d = RUN;
                    end else begin
                        enter_done = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The cycle that pauses does not advance the prescaler, so a pending tick survives the pause.
    always_comb begin
        presc_d = '0;
        if (state_q == RUN && state_d == RUN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end else if (state_d == PAUSE || (state_q == PAUSE && state_d == RUN)) begin
            presc_d = presc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '1;
            reload_q     <= '1;
            presc_q      <= '0;
            start_sync_q <= '0;
            load_sync_q  <= '0;
            start_prev_q <= 1'b0;
            load_prev_q  <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            reload_q     <= reload_d;
            presc_q      <= presc_d;
            start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], start_btn};
            load_sync_q  <= {load_sync_q[SYNC_STAGES-2:0], load_btn};
            start_prev_q <= start_sync_q[SYNC_STAGES-1];
            load_prev_q  <= load_sync_q[SYNC_STAGES-1];
            running_q    <= (state_d == RUN);
            done_q       <= (state_d == DONE);
            done_pulse_q <= enter_done;
        end
    end

    assign count      = count_q;
    assign running    = running_q;
    assign done       = done_q;
    assign done_pulse = done_pulse_q;

endmodule
